// File: rtl/xext_bridge_pkg.sv
// Shared definitions for the external parallel-bus bridge: FSM encoding,
// default parameter values and the channel-index width helper.
package xext_bridge_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_PAR_ADDR_W = 10;
  localparam int DEF_N_CH       = 4;
  localparam int DEF_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Channel-select width; a single channel still gets one address bit.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xext_timer.sv
// ACCESS watchdog for xext_bridge: counts enabled cycles since the last clear
// and flags the cycle in which the LIMIT-th enabled cycle completes.
module xext_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable)  cnt <= cnt + 1'b1;
  end

  // Expiry is seen during the LIMIT-th waiting cycle so the bridge leaves at its end.
  assign expired = enable && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/xext_bridge.sv
// Core-to-external parallel bus bridge (IDLE -> ACCESS -> DONE) over N_CH channels.
// Optional ACCESS watchdog enabled by defining XEXT_BRIDGE_TIMEOUT_EN.
module xext_bridge
  import xext_bridge_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PAR_ADDR_W = DEF_PAR_ADDR_W,
  parameter int N_CH       = DEF_N_CH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    sel,
  input  logic                                    we,
  input  logic [ch_width(N_CH)+PAR_ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]                       data_in,
  output logic [DATA_W-1:0]                       data_out,
  output logic                                    ready,
  output logic                                    err,
  output logic [PAR_ADDR_W-1:0]                   par_addr,
  output logic [DATA_W-1:0]                       par_out,
  output logic [N_CH-1:0]                         par_re,
  output logic [N_CH-1:0]                         par_we,
  input  logic [N_CH*DATA_W-1:0]                  par_in,
  input  logic [N_CH-1:0]                         par_ack
);

  localparam int CH_W = ch_width(N_CH);

  state_e            state;
  logic              we_q;
  logic              err_pend;
  logic [N_CH-1:0]   ch_mask;
  logic [CH_W-1:0]   req_ch;
  logic [N_CH-1:0]   req_dec;
  logic              req_bad;
  logic              ack_hit;
  logic [DATA_W-1:0] rd_word;

  assign req_ch = addr[CH_W+PAR_ADDR_W-1 -: CH_W];

  for (genvar k = 0; k < N_CH; k++) begin : g_dec
    assign req_dec[k] = (req_ch == CH_W'(k));
  end

  // No decoded channel means the index is beyond N_CH.
  assign req_bad = ~|req_dec;

  // Only the latched channel's ack and data are visible; others are masked off.
  always_comb begin
    ack_hit = |(par_ack & ch_mask);
    rd_word = '0;
    for (int k = 0; k < N_CH; k++)
      if (ch_mask[k]) rd_word = rd_word | par_in[k*DATA_W +: DATA_W];
  end

`ifdef XEXT_BRIDGE_TIMEOUT_EN
  logic expired;

  xext_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .enable  ((state == ACCESS) && !ack_hit),
    .expired (expired)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      err_pend <= 1'b0;
      ch_mask  <= '0;
      data_out <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      par_addr <= '0;
      par_out  <= '0;
      par_re   <= '0;
      par_we   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          if (sel) begin
            we_q     <= we;
            ch_mask  <= req_dec;
            par_addr <= addr[PAR_ADDR_W-1:0];
            par_out  <= data_in;
            if (req_bad) begin
              // Error completes through DONE one cycle later, matching normal latency.
              data_out <= '0;
              err_pend <= 1'b1;
              state    <= DONE;
            end else begin
              par_re <= we ? '0 : req_dec;
              par_we <= we ? req_dec : '0;
              state  <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            if (!we_q) data_out <= rd_word;
            par_re <= '0;
            par_we <= '0;
            ready  <= 1'b1;
            state  <= DONE;
          end
`ifdef XEXT_BRIDGE_TIMEOUT_EN
          else if (expired) begin
            data_out <= '0;
            par_re   <= '0;
            par_we   <= '0;
            ready    <= 1'b1;
            err      <= 1'b1;
            state    <= DONE;
          end
`endif
        end
        DONE: begin
          if (err_pend) begin
            err_pend <= 1'b0;
            ready    <= 1'b1;
            err      <= 1'b1;
          end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xext_bridge.sv
// Scoreboard bench for xext_bridge (N_CH=3 so channel index 3 is out of range).
// Covers the XEXT_BRIDGE_TIMEOUT_EN build and the default build.
module tb_xext_bridge;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NC = 3;
  localparam int CW = 2;
  localparam int TO = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                sel;
  logic                we;
  logic [CW+AW-1:0]    addr;
  logic [DW-1:0]       data_in;
  logic [DW-1:0]       data_out;
  logic                ready;
  logic                err;
  logic [AW-1:0]       par_addr;
  logic [DW-1:0]       par_out;
  logic [NC-1:0]       par_re;
  logic [NC-1:0]       par_we;
  logic [NC*DW-1:0]    par_in;
  logic [NC-1:0]       par_ack;

  xext_bridge #(.DATA_W(DW), .PAR_ADDR_W(AW), .N_CH(NC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ready(ready), .err(err), .par_addr(par_addr),
    .par_out(par_out), .par_re(par_re), .par_we(par_we), .par_in(par_in),
    .par_ack(par_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] dout; logic err; } exp_t;
  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] mdl_dout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Completion monitor: every ready pulse must match the oldest issued request.
  always @(negedge clk) begin
    if (!rst) begin
      if (err && !ready) chk("err_without_ready", err, 1'b0);
      if (ready) begin
        if (sb.size() == 0) chk("spurious_ready", ready, 1'b0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("data_out", data_out, e.dout);
          chk("err", err, e.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic issue(input logic w, input int ch, input logic [AW-1:0] off, input logic [DW-1:0] wd);
    @(negedge clk);
    sel = 1'b1; we = w; addr = {CW'(ch), off}; data_in = wd;
    @(posedge clk); #1;
    // Keep sel up with scrambled request fields; the bridge must ignore them.
    we = ~w; addr = ~addr; data_in = ~wd;
  endtask

  task automatic xact(input logic w, input int ch, input logic [AW-1:0] off,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rv,
                      input int dly, input int junk);
    logic [NC-1:0] oh;
    exp_t          e;
    bit            bad;
    bad = (ch >= NC);
    oh  = bad ? '0 : NC'(1) << ch;
    if (bad) mdl_dout = '0;
    else if (!w) mdl_dout = rv;
    e.dout = mdl_dout; e.err = bad;
    sb.push_back(e);
    issue(w, ch, off, wd);
    if (bad) begin
      chk("bad_no_strobe", {par_re, par_we}, '0);
      @(posedge clk); #1;
      chk("bad_ready_n2", ready, 1'b1);
    end else begin
      for (int k = 0; k <= dly; k++) begin
        chk("strobe", {par_re, par_we}, w ? {NC'(0), oh} : {oh, NC'(0)});
        chk("par_addr", par_addr, off);
        chk("par_out", par_out, wd);
        if (k == dly) begin
          par_ack = oh;
          par_in[ch*DW +: DW] = rv;
        end else if (junk >= 0) par_ack = NC'(1) << junk;
        @(posedge clk); #1;
        par_ack = '0;
      end
      chk("ready_latency", ready, 1'b1);
      chk("strobe_drop", {par_re, par_we}, '0);
    end
    // sel still high across the DONE edge: must not start a new transaction.
    @(posedge clk); #1;
    sel = 1'b0;
    chk("idle_after_done", {ready, par_re, par_we}, '0);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; data_in = '0; par_ack = '0;
    for (int k = 0; k < NC; k++) par_in[k*DW +: DW] = $urandom;
    mdl_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {data_out, ready, err, par_addr, par_out, par_re, par_we}, '0);
    rst = 1'b0;

    xact(1'b0, 2, 10'h005, 32'h0, 32'hDEADBEEF, 0, -1);
    xact(1'b1, 0, 10'h011, 32'h12345678, 32'h0, 5, -1);
    xact(1'b0, 3, 10'h020, 32'h0, 32'h0, 0, -1);
    xact(1'b0, 2, 10'h3FF, 32'h0, 32'hA5A5F00D, 4, 1);
    xact(1'b1, 1, 10'h000, 32'hFFFFFFFF, 32'h0, 1, 0);

    for (int i = 0; i < 12; i++)
      xact(1'($urandom_range(0, 1)), $urandom_range(0, 3), AW'($urandom),
           $urandom, $urandom, $urandom_range(0, 4), -1);

`ifdef XEXT_BRIDGE_TIMEOUT_EN
    begin
      exp_t e;
      mdl_dout = '0;
      e.dout = '0; e.err = 1'b1;
      sb.push_back(e);
      issue(1'b0, 1, 10'h042, 32'h0);
      ok = 1;
      for (int k = 0; k < TO; k++) begin
        if ({par_re, par_we} !== {3'b010, 3'b000} || ready !== 1'b0) ok = 0;
        @(posedge clk); #1;
      end
      chk("timeout_strobe_held", ok, 1'b1);
      chk("timeout_ready_err", {ready, err}, 2'b11);
      chk("timeout_strobe_drop", {par_re, par_we}, '0);
      @(posedge clk); #1;
      sel = 1'b0;
    end
`else
    issue(1'b0, 1, 10'h042, 32'h0);
    ok = 1;
    for (int k = 0; k < 1000; k++) begin
      if ({par_re, par_we} !== {3'b010, 3'b000} || ready !== 1'b0) ok = 0;
      @(posedge clk); #1;
    end
    chk("noack_strobe_held", ok, 1'b1);
    sel = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    mdl_dout = '0;
    chk("noack_rst_clear", {data_out, ready, err, par_addr, par_out, par_re, par_we}, '0);
`endif

    // Reset two cycles into ACCESS drops the request; a late ack must do nothing.
    issue(1'b0, 0, 10'h0AA, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; sel = 1'b0;
    mdl_dout = '0;
    par_ack = 3'b001;
    chk("midrst_outputs", {data_out, ready, err, par_addr, par_out, par_re, par_we}, '0);
    @(posedge clk); #1;
    par_ack = '0;
    chk("midrst_no_ready", {ready, par_re, par_we}, '0);

    xact(1'b0, 0, 10'h0AB, 32'h0, 32'hC0FFEE11, 2, -1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
